// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD display widths, limits and helpers
package bcd_disp_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running divide-by-DIV counter emitting a one-cycle tick
module scan_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] div_cnt;
  assign tick = div_cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    if (rst) div_cnt <= '0;
    else div_cnt <= tick ? '0 : div_cnt + 1'b1;
endmodule

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: frame-atomic multiplexed BCD digit scanner with leading-zero blanking
module bcd_digit_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic [BCD_W-1:0]            q,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        blank,
  output logic                        pending,
  output logic                        frame_start
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic tick, commit, above_zero;
  logic [IW-1:0] idx;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] shadow, disp;
  logic [NUM_DIGITS-1:0] blank_vec;
  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );
  assign commit = tick && idx == LAST;
  // Walk from the MSD down; a non-BCD code breaks the run of leading zeros.
  always_comb begin
    blank_vec = '0;
    above_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blank_vec[i] = !is_bcd(disp[i]) || (BLANK_LZ != 0 && i != 0 && disp[i] == '0 && above_zero);
      above_zero = above_zero && disp[i] == '0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      shadow <= '0;
      disp <= '0;
      pending <= 1'b0;
      q <= '0;
      an <= '1;
      blank <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (tick) idx <= idx == LAST ? '0 : idx + 1'b1;
      if (commit && pending) disp <= shadow;
      if (load) shadow <= bcd_in;
      pending <= load || (pending && !commit);
      frame_start <= commit;
      q <= disp[idx];
      blank <= blank_vec[idx];
      an <= blank_vec[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
    end
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb_bcd_digit_scanner: randomized check of three scanner configurations against a cycle-count model
module tb_bcd_digit_scanner;
  logic clk = 0, rst = 1, load = 0;
  logic [15:0] bcd_in = '0;
  logic [3:0] q_o[3], an_o[3];
  logic bl_o[3], pd_o[3], fs_o[3];
  int checks = 0, failures = 0;
  int m_t[3];
  logic [15:0] m_sh[3], m_disp[3];
  bit m_pend[3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(g == 2 ? 1 : 4), .BLANK_LZ(g == 1 ? 0 : 1)) u_dut (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
      .q(q_o[g]), .an(an_o[g]), .blank(bl_o[g]), .pending(pd_o[g]), .frame_start(fs_o[g])
    );
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Model: slot and frame position follow from cycles elapsed since reset release.
  task automatic step_and_check(bit r, bit l, logic [15:0] b);
    logic [3:0] e_q[3], e_an[3];
    bit e_bl[3], e_fs[3];
    rst = r; load = l; bcd_in = b;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int dv, slot;
      bit lz;
      dv = k == 2 ? 1 : 4;
      lz = k != 1;
      if (r) begin
        m_t[k] = 0; m_sh[k] = 0; m_disp[k] = 0; m_pend[k] = 0;
        e_q[k] = 0; e_an[k] = 4'hF; e_bl[k] = 1; e_fs[k] = 0;
      end else begin
        slot = (m_t[k] / dv) % 4;
        e_q[k] = 4'((m_disp[k] >> (4 * slot)) & 16'hF);
        e_bl[k] = e_q[k] > 9 || (lz && slot > 0 && (m_disp[k] >> (4 * slot)) == 0);
        e_an[k] = e_bl[k] ? 4'hF : ~(4'b1 << slot);
        e_fs[k] = (m_t[k] % (4 * dv)) == 4 * dv - 1;
        if (e_fs[k] && m_pend[k]) begin
          m_disp[k] = m_sh[k];
          m_pend[k] = 0;
        end
        if (l) begin
          m_sh[k] = b;
          m_pend[k] = 1;
        end
        m_t[k]++;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("q%0d", k), 32'(q_o[k]), 32'(e_q[k]));
      check($sformatf("an%0d", k), 32'(an_o[k]), 32'(e_an[k]));
      check($sformatf("blank%0d", k), 32'(bl_o[k]), 32'(e_bl[k]));
      check($sformatf("pending%0d", k), 32'(pd_o[k]), 32'(m_pend[k]));
      check($sformatf("frame_start%0d", k), 32'(fs_o[k]), 32'(e_fs[k]));
    end
  endtask
  task automatic idle_until_phase(int ph);
    for (int i = 0; i < 32 && (m_t[0] % 16) != ph; i++) step_and_check(0, 0, 0);
    check("phase_reached", 32'(m_t[0] % 16), 32'(ph));
  endtask
  task automatic show_frames(logic [15:0] v);
    step_and_check(0, 1, v);
    for (int i = 0; i < 40; i++) step_and_check(0, 0, 0);
  endtask
  initial begin
    repeat (3) step_and_check(1, 0, 0);
    for (int i = 0; i < 36; i++) step_and_check(0, i == 5, 16'h1234);
    show_frames(16'h0050);
    show_frames(16'h00A7);
    show_frames(16'h0000);
    show_frames(16'hB000);
    idle_until_phase(0);
    step_and_check(0, 1, 16'h2222);
    idle_until_phase(15);
    step_and_check(0, 1, 16'h1111);
    check("s5_pend_after_commit", 32'(pd_o[0]), 1);
    for (int i = 0; i < 40; i++) step_and_check(0, 0, 0);
    check("s5_pend_cleared", 32'(pd_o[0]), 0);
    idle_until_phase(6);
    step_and_check(0, 1, 16'h9876);
    step_and_check(0, 0, 0);
    step_and_check(1, 0, 0);
    check("rst_pend_clear", 32'(pd_o[0]), 0);
    for (int i = 0; i < 40; i++) step_and_check(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int d = 0; d < 4; d++)
        if ($urandom_range(0, 2) == 0) v[4*d+:4] = 4'h0;
        else if ($urandom_range(0, 3) != 0) v[4*d+:4] = 4'($urandom_range(0, 9));
      step_and_check($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, v);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
